// File: rtl/sig_pkg.sv
// Shared helpers for the sig_* signal-chain blocks.
// Covers delay limits, channel slicing and output source selection.
package sig_pkg;

  // Where the delay line output comes from on the cycle after a sample.
  typedef enum logic {
    SRC_HOLD = 1'b0,
    SRC_RAM  = 1'b1
  } out_src_e;

  // Largest usable delay for a RAM of 2^log2_depth words.
  function automatic int unsigned max_delay(input int unsigned log2_depth);
    return (32'd1 << log2_depth) - 32'd1;
  endfunction

  // LSB of channel c in a packed multi-channel word.
  function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned width);
    return c * width;
  endfunction

endpackage

// File: rtl/sig_dpram.sv
// Simple dual-port RAM with a synchronous write and a registered, enabled read.
// Read data appears one clock after rd_en and then holds; there is no backpressure.
module sig_dpram #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/sig_delay_mc.sv
// Multi-channel programmable sample delay with fill mute, shadowed delay and clamp flag.
// One clock from data_valid to out_valid; no backpressure, every valid sample is accepted.
module sig_delay_mc
  import sig_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int CHANNELS    = 2,
  parameter int LOG2_DEPTH  = 10,
  parameter int DELAY_WIDTH = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [DELAY_WIDTH-1:0]    delay,
  input  logic                      delay_upd,
  input  logic                      flush,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic                      out_valid,
  output logic                      delay_clamped
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int unsigned DEPTH_MAX = max_delay(LOG2_DEPTH);
  localparam logic [LOG2_DEPTH-1:0] MAX_D = LOG2_DEPTH'(DEPTH_MAX);

  logic [LOG2_DEPTH-1:0] d_act;
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] fill;
  logic [LOG2_DEPTH-1:0] rd_addr;
  logic                  wr_en;
  logic                  req_over;
  logic                  hist_ok;
  logic [DW-1:0]         rd_dat;
  logic [DW-1:0]         byp_q;
  out_src_e              src_q;

  assign wr_en    = data_valid & ~flush;
  assign rd_addr  = wptr - d_act;
  assign hist_ok  = (fill >= d_act);
  assign req_over = (32'(delay) > DEPTH_MAX);

  // Active delay only moves on the update strobe, so the current sample
  // always sees the delay that was in force before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_act         <= '0;
      delay_clamped <= 1'b0;
    end else if (delay_upd) begin
      d_act <= req_over ? MAX_D : LOG2_DEPTH'(delay);
      if (req_over) delay_clamped <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      byp_q     <= '0;
      src_q     <= SRC_HOLD;
    end else if (flush) begin
      wptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      byp_q     <= '0;
      src_q     <= SRC_HOLD;
    end else if (data_valid) begin
      wptr      <= wptr + 1'b1;
      out_valid <= 1'b1;
      if (fill != MAX_D) fill <= fill + 1'b1;
      if (d_act == '0) begin
        byp_q <= data_in;
        src_q <= SRC_HOLD;
      end else if (hist_ok) begin
        src_q <= SRC_RAM;
      end else begin
        byp_q <= '0;
        src_q <= SRC_HOLD;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  // The read is issued on the sample edge itself; its registered result lines
  // up with out_valid, and rd_en gating keeps it stable between strobes.
  sig_dpram #(
    .AW (LOG2_DEPTH),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_dat  (data_in),
    .rd_en   (wr_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign data_out[ch_lsb(c, WIDTH) +: WIDTH] =
      (src_q == SRC_RAM) ? rd_dat[ch_lsb(c, WIDTH) +: WIDTH]
                         : byp_q[ch_lsb(c, WIDTH) +: WIDTH];
  end

endmodule

// File: tb/tb_sig_delay_mc.sv
// Randomized bench for sig_delay_mc against a sample-history reference model.
// LOG2_DEPTH=4 so that clamping and pointer wrap are reached quickly.
module tb_sig_delay_mc;

  localparam int WIDTH  = 12;
  localparam int CH     = 2;
  localparam int L2D    = 4;
  localparam int DLYW   = 15;
  localparam int MAXD   = 15;
  localparam int DW     = WIDTH * CH;

  logic            clk;
  logic            rst;
  logic            data_valid;
  logic [DW-1:0]   data_in;
  logic [DLYW-1:0] delay;
  logic            delay_upd;
  logic            flush;
  logic [DW-1:0]   data_out;
  logic            out_valid;
  logic            delay_clamped;

  sig_delay_mc #(
    .WIDTH       (WIDTH),
    .CHANNELS    (CH),
    .LOG2_DEPTH  (L2D),
    .DELAY_WIDTH (DLYW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .delay         (delay),
    .delay_upd     (delay_upd),
    .flush         (flush),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .delay_clamped (delay_clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: every sample written since the last flush/reset.
  logic [DW-1:0] hist[$];
  int            m_d;
  bit            m_clamp;
  logic [DW-1:0] exp_out;
  bit            exp_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_d     = 0;
    m_clamp = 1'b0;
    exp_out = '0;
    exp_vld = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vld"},   32'(out_valid),     32'(exp_vld));
    check({tag, ".dat"},   32'(data_out),      32'(exp_out));
    check({tag, ".clamp"}, 32'(delay_clamped), 32'(m_clamp));
  endtask

  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic u, input int dl, input logic f);
    data_valid = v;
    data_in    = d;
    delay_upd  = u;
    delay      = DLYW'(dl);
    flush      = f;
    @(posedge clk);
    if (f) begin
      hist.delete();
      exp_out = '0;
      exp_vld = 1'b0;
    end else if (v) begin
      if (m_d == 0)                exp_out = d;
      else if (hist.size() >= m_d) exp_out = hist[hist.size() - m_d];
      else                         exp_out = '0;
      hist.push_back(d);
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    if (u) begin
      if (dl > MAXD) m_clamp = 1'b1;
      m_d = (dl > MAXD) ? MAXD : dl;
    end
    #1;
    check_all(tag);
    data_valid = 1'b0;
    delay_upd  = 1'b0;
    flush      = 1'b0;
  endtask

  function automatic logic [DW-1:0] ramp(input int n);
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    c0 = WIDTH'(n);
    c1 = WIDTH'(n + 'h100);
    return {c1, c0};
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  int n;

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; delay = '0; delay_upd = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Basic delay of 3 on a ramp
    step("basic_upd", 1'b0, '0, 1'b1, 3, 1'b0);
    for (n = 0; n < 20; n++) step("basic", 1'b1, ramp(n), 1'b0, 0, 1'b0);

    // Gated valid, about 25% duty
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        step("gated", 1'b1, ramp(n), 1'b0, 0, 1'b0);
        n++;
      end else begin
        step("gated_idle", 1'b0, rnd(), 1'b0, 0, 1'b0);
      end
    end

    // Delay change with full history, then update coincident with a sample
    step("chg_upd8", 1'b0, '0, 1'b1, 8, 1'b0);
    for (int i = 0; i < 5; i++) step("chg8", 1'b1, rnd(), 1'b0, 0, 1'b0);
    step("chg_upd3", 1'b0, '0, 1'b1, 3, 1'b0);
    for (int i = 0; i < 3; i++) step("chg3", 1'b1, rnd(), 1'b0, 0, 1'b0);
    step("chg_upd2_same", 1'b1, rnd(), 1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) step("chg2", 1'b1, rnd(), 1'b0, 0, 1'b0);

    // Zero delay pass-through, then clamp from 20 to 15
    step("zero_upd", 1'b0, '0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 6; i++) step("zero", 1'b1, rnd(), 1'b0, 0, 1'b0);
    step("zero_idle", 1'b0, rnd(), 1'b0, 0, 1'b0);
    step("clamp_upd", 1'b0, '0, 1'b1, 20, 1'b0);
    for (int i = 0; i < 20; i++) step("clamp", 1'b1, rnd(), 1'b0, 0, 1'b0);
    step("clamp_upd_ok", 1'b0, '0, 1'b1, 4, 1'b0);
    step("clamp_sticky", 1'b1, rnd(), 1'b0, 0, 1'b0);

    // Flush during a stream at delay 5; flush-cycle sample is dropped
    step("fl_upd", 1'b0, '0, 1'b1, 5, 1'b0);
    for (int i = 0; i < 10; i++) step("fl_pre", 1'b1, rnd(), 1'b0, 0, 1'b0);
    step("flush", 1'b1, rnd(), 1'b0, 0, 1'b1);
    for (int i = 0; i < 10; i++) step("fl_post", 1'b1, rnd(), 1'b0, 0, 1'b0);
    step("flush_upd", 1'b0, '0, 1'b1, 7, 1'b1);
    for (int i = 0; i < 9; i++) step("fl_upd_post", 1'b1, rnd(), 1'b0, 0, 1'b0);

    // Wrap-around at maximum delay
    step("wrap_fl", 1'b0, '0, 1'b1, 15, 1'b1);
    for (int i = 0; i < 100; i++) step("wrap", ($urandom_range(7, 0) != 0), rnd(), 1'b0, 0, 1'b0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, rnd(), 1'b0, 0, 1'b0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_upd", 1'b0, '0, 1'b1, 4, 1'b0);
    for (int i = 0; i < 10; i++) step("post_rst", 1'b1, rnd(), 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
